servo_ramp_pwm: RTL and testbench
=================================

SERVO_RAMP_PWM -- requirements
Module: servo_ramp_pwm

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 25_000_000, giving the clock frequency (documentation only).
REQ-002 The block SHALL have parameter N_CH, default 4, giving the number of servo channels (1..16).
REQ-003 The block SHALL have parameter PERIOD_CLKS, default 500_000, giving the PWM frame length in clocks (20 ms).
REQ-004 The block SHALL have parameter PULSE_MIN_CLKS, default 25_000, giving the minimum pulse width (1.0 ms).
REQ-005 The block SHALL have parameter PULSE_MAX_CLKS, default 50_000, giving the maximum pulse width (2.0 ms).
REQ-006 The block SHALL have parameter PULSE_INIT_CLKS, default 37_500, giving the reset pulse width for every channel.
REQ-007 The block SHALL have parameter STEP_CLKS, default 250, giving the maximum pulse-width change per frame; 0 means jump immediately.
REQ-008 The block SHALL have parameter CNT_W, default 19, giving the counter and pulse width; CH_W = max(1, clog2(N_CH)).
REQ-009 The block SHALL have port clk, input, width 1, as the clock, sampled on the rising edge.
REQ-010 The block SHALL have port reset, input, width 1, as an asynchronous, active-high reset.
REQ-011 The block SHALL have port cmd_valid, input, width 1, indicating a command is presented.
REQ-012 The block SHALL have port cmd_ready, output, width 1, indicating the block accepts a command this cycle.
REQ-013 The block SHALL have port cmd_ch, input, width CH_W, giving the target channel index.
REQ-014 The block SHALL have port cmd_pulse, input, width CNT_W, giving the requested pulse width in clocks.
REQ-015 The block SHALL have port enable, input, width N_CH, as the per-channel output enable.
REQ-016 The block SHALL have port pwm_out, output, width N_CH, carrying the per-channel PWM outputs.
REQ-017 The block SHALL have port busy, output, width N_CH, high while a channel's current width differs from its target.
REQ-018 The block SHALL have port frame_tick, output, width 1, as a one-cycle pulse on the last clock of each frame.

Function
REQ-019 The frame counter SHALL count 0..PERIOD_CLKS-1, then wrap to 0.
REQ-020 frame_tick SHALL be 1 exactly when the counter equals PERIOD_CLKS-1.
REQ-021 cmd_ready SHALL be 1 in every non-reset cycle except the frame_tick cycle, where it is 0.
REQ-022 A command SHALL be accepted when cmd_valid and cmd_ready are both 1; the channel's target SHALL be updated at that edge.
REQ-023 An accepted cmd_pulse SHALL be clamped to [PULSE_MIN_CLKS, PULSE_MAX_CLKS] before it is stored.
REQ-024 A command with cmd_ch >= N_CH SHALL be accepted and ignored, with no state change.
REQ-025 On the frame_tick edge, each channel's current width SHALL move toward its target by min(STEP_CLKS, |target-current|); with STEP_CLKS=0 it SHALL become equal to the target.
REQ-026 Current width SHALL change only on the frame_tick edge, so no frame contains a truncated or stretched pulse.
REQ-027 On the frame_tick edge, enable SHALL be sampled into a per-channel enable register that holds for the whole next frame.
REQ-028 pwm_out[i] SHALL be 1 iff en_q[i]=1 and counter < current[i]; pulse length = current[i] clocks starting at counter 0.
REQ-029 busy[i] SHALL equal (current[i] != target[i]).
REQ-030 Arithmetic SHALL be unsigned CNT_W-bit, with no overflow for any parameter set where PULSE_MAX_CLKS+STEP_CLKS < 2^CNT_W.

Reset
REQ-031 While reset=1: counter=0, target[i]=current[i]=PULSE_INIT_CLKS, en_q=0, pwm_out=0, busy=0, frame_tick=0, cmd_ready=0.
REQ-032 After reset deasserts, the first frame SHALL start at counter 0 with pwm_out low, because en_q is not loaded until the first frame_tick.
REQ-033 Reset asserted mid-frame or mid-ramp SHALL abort immediately to the reset values; pending targets are lost.

Verification
(Bench parameters: N_CH=2, PERIOD_CLKS=100, MIN=10, MAX=20, INIT=15, STEP=2.)
REQ-034 The bench SHALL cover: reset release, enable=2'b11 -> pwm_out=0 for frame 0; from frame 1, both channels high for exactly 15 clocks every 100.
REQ-035 The bench SHALL cover: command ch0 pulse=19 -> busy[0]=1; widths 17, 19 in the next two frames; busy[0]=0 after the second frame_tick.
REQ-036 The bench SHALL cover: command ch1 pulse=3, then pulse=60 -> stored targets 10, then 20 (clamped).
REQ-037 The bench SHALL cover: cmd_valid held during the frame_tick cycle -> cmd_ready=0 and the command is accepted the following cycle.
REQ-038 The bench SHALL cover: enable[0] dropped at counter 5 -> current pulse completes; pwm_out[0]=0 for the whole next frame.
REQ-039 The bench SHALL cover: reset asserted at counter 50 during a ramp -> all outputs 0 asynchronously; after release, widths are 15 again.

Source files
------------

// File: rtl/servo_ramp_pwm.sv
// servo_ramp_pwm: multi-channel hobby-servo PWM generator with slew-limited width ramping.
//
// A free-running frame counter (0..PERIOD_CLKS-1) sets the PWM frame. Commands write a
// clamped target pulse width per channel. On the last clock of each frame (frame_tick),
// every channel's current width steps toward its target and the enable mask is latched.
// Widths and enables only change on that edge, so every emitted pulse is whole.
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   cmd_valid   command presented
//   cmd_ready   command accepted this cycle (low on the frame_tick cycle and in reset)
//   cmd_ch      target channel; indices >= N_CH are accepted and ignored
//   cmd_pulse   requested pulse width in clocks, clamped to [PULSE_MIN_CLKS, PULSE_MAX_CLKS]
//   enable      per-channel output enable, sampled at frame_tick
//   pwm_out     per-channel PWM outputs
//   busy        per-channel: current width differs from target
//   frame_tick  one-cycle pulse on the last clock of each frame
module servo_ramp_pwm #(
  parameter int CLK_FREQ_HZ     = 25_000_000,
  parameter int N_CH            = 4,
  parameter int PERIOD_CLKS     = 500_000,
  parameter int PULSE_MIN_CLKS  = 25_000,
  parameter int PULSE_MAX_CLKS  = 50_000,
  parameter int PULSE_INIT_CLKS = 37_500,
  parameter int STEP_CLKS       = 250,
  parameter int CNT_W           = 19,
  localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CH_W-1:0]  cmd_ch,
  input  logic [CNT_W-1:0] cmd_pulse,
  input  logic [N_CH-1:0]  enable,
  output logic [N_CH-1:0]  pwm_out,
  output logic [N_CH-1:0]  busy,
  output logic             frame_tick
);

  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(PERIOD_CLKS - 1);
  localparam logic [CNT_W-1:0] L_MIN  = CNT_W'(PULSE_MIN_CLKS);
  localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(PULSE_MAX_CLKS);
  localparam logic [CNT_W-1:0] L_INIT = CNT_W'(PULSE_INIT_CLKS);
  localparam logic [CNT_W-1:0] L_STEP = CNT_W'(STEP_CLKS);

  logic [CNT_W-1:0] r_cnt;
  logic [N_CH-1:0]  r_en;
  logic             w_tick;
  logic             w_accept;
  logic [CNT_W-1:0] w_clamped;

  assign w_tick     = (r_cnt == L_LAST);
  assign frame_tick = w_tick && !reset;
  assign cmd_ready  = !reset && !w_tick;
  assign w_accept   = cmd_valid && cmd_ready;

  always_comb begin
    w_clamped = cmd_pulse;
    if (cmd_pulse < L_MIN) begin
      w_clamped = L_MIN;
    end else if (cmd_pulse > L_MAX) begin
      w_clamped = L_MAX;
    end
  end

  // Frame counter and the enable mask that holds for the whole following frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_en  <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_en <= enable;
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_cur;
    logic [CNT_W-1:0] r_tgt;
    logic             w_up;
    logic [CNT_W-1:0] w_diff;
    logic [CNT_W-1:0] w_delta;
    logic [CNT_W-1:0] w_next;
    logic             w_wr;

    // Out-of-range channel indices never match any gi, so they are dropped silently.
    assign w_wr = w_accept && (cmd_ch == CH_W'(gi));

    always_comb begin
      w_up    = (r_tgt > r_cur);
      w_diff  = w_up ? (r_tgt - r_cur) : (r_cur - r_tgt);
      // STEP_CLKS of 0 means jump straight to the target.
      w_delta = ((STEP_CLKS == 0) || (w_diff < L_STEP)) ? w_diff : L_STEP;
      w_next  = w_up ? (r_cur + w_delta) : (r_cur - w_delta);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cur <= L_INIT;
        r_tgt <= L_INIT;
      end else begin
        if (w_wr) begin
          r_tgt <= w_clamped;
        end
        if (w_tick) begin
          r_cur <= w_next;
        end
      end
    end

    assign pwm_out[gi] = r_en[gi] && (r_cnt < r_cur);
    assign busy[gi]    = (r_cur != r_tgt);
  end

endmodule

// File: tb/tb_servo_ramp_pwm.sv
// Directed bench for servo_ramp_pwm with a small parameter set
// (2 channels, 100-clock frame, width 10..20, init 15, step 2).
module tb_servo_ramp_pwm;

  localparam int N_CH  = 2;
  localparam int CNT_W = 8;
  localparam int CH_W  = 1;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CH_W-1:0]  cmd_ch;
  logic [CNT_W-1:0] cmd_pulse;
  logic [N_CH-1:0]  enable;
  logic [N_CH-1:0]  pwm_out;
  logic [N_CH-1:0]  busy;
  logic             frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  servo_ramp_pwm #(
    .CLK_FREQ_HZ    (25_000_000),
    .N_CH           (N_CH),
    .PERIOD_CLKS    (100),
    .PULSE_MIN_CLKS (10),
    .PULSE_MAX_CLKS (20),
    .PULSE_INIT_CLKS(15),
    .STEP_CLKS      (2),
    .CNT_W          (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ch    (cmd_ch),
    .cmd_pulse (cmd_pulse),
    .enable    (enable),
    .pwm_out   (pwm_out),
    .busy      (busy),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Samples on negedges until frame_tick is seen, counting high cycles per channel.
  // When called at a frame_tick negedge the counts are the full-frame pulse widths.
  // enable is changed to chg_en right after the sample with counter == chg_at.
  task automatic run_frame(input string tag, input int chg_at, input logic [1:0] chg_en,
                           output int h0, output int h1, output int n);
    bit done;
    h0 = 0;
    h1 = 0;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      if (n == chg_at) enable = chg_en;
      n++;
      if (frame_tick === 1'b1) done = 1'b1;
    end
    chk({tag, "_tick_seen"}, int'(done), 1);
  endtask

  // Presents a command on the first cycle of a frame; leaves the bench at counter 1.
  task automatic issue_cmd(input logic [CH_W-1:0] ch, input int pulse);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_pulse = CNT_W'(pulse);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  int h0, h1, n;

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_ch    = '0;
    cmd_pulse = '0;
    enable    = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_ready", int'(cmd_ready), 0);

    // Reset release with both channels enabled: frame 0 stays low.
    enable = 2'b11;
    reset  = 1'b0;
    #1;
    chk("rel_ready", int'(cmd_ready), 1);
    run_frame("f0", -1, 2'b11, h0, h1, n);
    chk("f0_pwm0", h0, 0);
    chk("f0_pwm1", h1, 0);
    run_frame("f1", -1, 2'b11, h0, h1, n);
    chk("f1_pwm0", h0, 15);
    chk("f1_pwm1", h1, 15);
    chk("f1_len", n, 100);

    // ch0 -> 19: ramps 17 then 19.
    issue_cmd(1'b0, 19);
    chk("c0_busy", int'(busy), 1);
    run_frame("f2", -1, 2'b11, h0, h1, n);
    chk("f2_busy", int'(busy), 1);
    run_frame("f3", -1, 2'b11, h0, h1, n);
    chk("f3_pwm0", h0, 17);
    chk("f3_pwm1", h1, 15);
    chk("f3_busy", int'(busy), 1);
    run_frame("f4", -1, 2'b11, h0, h1, n);
    chk("f4_pwm0", h0, 19);
    chk("f4_busy", int'(busy), 0);

    // ch1 -> 3, clamped to 10: ramps 13, 11, 10.
    issue_cmd(1'b1, 3);
    chk("c1_busy", int'(busy), 2);
    run_frame("f5", -1, 2'b11, h0, h1, n);
    for (int f = 0; f < 3; f++) begin
      run_frame("f6_8", -1, 2'b11, h0, h1, n);
      chk("lo_pwm0", h0, 19);
      chk("lo_pwm1", h1, (f == 2) ? 10 : 13 - 2 * f);
    end
    chk("f8_busy", int'(busy), 0);

    // ch1 -> 60 held across the frame_tick cycle: refused there, taken next cycle.
    cmd_valid = 1'b1;
    cmd_ch    = 1'b1;
    cmd_pulse = 8'd60;
    #1;
    chk("hold_tick", int'(frame_tick), 1);
    chk("hold_ready_tick", int'(cmd_ready), 0);
    @(negedge clk);
    chk("hold_ready_next", int'(cmd_ready), 1);
    chk("hold_busy_before", int'(busy), 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hold_busy_after", int'(busy), 2);
    run_frame("f9", -1, 2'b11, h0, h1, n);
    // Clamped to 20: ramps 12, 14, 16, 18, 20.
    for (int f = 0; f < 5; f++) begin
      run_frame("f10_14", -1, 2'b11, h0, h1, n);
      chk("hi_pwm1", h1, 12 + 2 * f);
    end
    chk("f14_busy", int'(busy), 0);

    // enable[0] dropped at counter 5: pulse completes, next frame silent on ch0.
    run_frame("f15", 5, 2'b10, h0, h1, n);
    chk("f15_pwm0", h0, 19);
    chk("f15_pwm1", h1, 20);
    run_frame("f16", -1, 2'b10, h0, h1, n);
    chk("f16_pwm0", h0, 0);
    chk("f16_pwm1", h1, 20);

    // Ramp ch0 19 -> 10, then reset at counter 50 mid-ramp.
    enable = 2'b11;
    issue_cmd(1'b0, 10);
    run_frame("f17", -1, 2'b11, h0, h1, n);
    run_frame("f18", -1, 2'b11, h0, h1, n);
    chk("f18_pwm0", h0, 17);
    chk("f18_pwm1", h1, 20);
    repeat (51) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    chk("mid_ready", int'(cmd_ready), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pwm", int'(pwm_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(cmd_ready), 0);
    chk("arst_tick", int'(frame_tick), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_frame("r0", -1, 2'b11, h0, h1, n);
    chk("r0_pwm0", h0, 0);
    chk("r0_pwm1", h1, 0);
    run_frame("r1", -1, 2'b11, h0, h1, n);
    chk("r1_pwm0", h0, 15);
    chk("r1_pwm1", h1, 15);
    chk("r1_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
